// File: rtl/ring_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ring_pkg : slot-type codes, widths, slot record and FSM state encoding      |
// | Rev 1.0  : initial release                                                  |
// +-----------------------------------------------------------------------------+
package ring_pkg;

  localparam int RING_W = 32;
  localparam int CORE_W = 4;
  localparam int SLOT_W = 4;

  localparam logic [SLOT_W-1:0] SLOT_NULL    = 4'd7;
  localparam logic [SLOT_W-1:0] SLOT_TOKEN   = 4'd1;
  localparam logic [SLOT_W-1:0] SLOT_MESSAGE = 4'd8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INJECT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef struct packed {
    logic [RING_W-1:0] data;
    logic [SLOT_W-1:0] slotType;
    logic [CORE_W-1:0] source;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/ring_token_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ring_token_arbiter_if : requester-side bundle between clients and ring stop |
// | Rev 1.0  : initial release                                                  |
// +-----------------------------------------------------------------------------+
interface ring_token_arbiter_if
  import ring_pkg::*;
#(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]        wantsToken;
  logic [NREQ-1:0]        acquireToken;
  logic [NREQ-1:0]        driveRing;
  logic [RING_W*NREQ-1:0] reqRingOut;
  logic [SLOT_W*NREQ-1:0] reqSlotType;
  logic [CORE_W*NREQ-1:0] reqSource;

  modport master (
    output wantsToken, driveRing, reqRingOut, reqSlotType, reqSource,
    input  acquireToken
  );

  modport slave (
    input  wantsToken, driveRing, reqRingOut, reqSlotType, reqSource,
    output acquireToken
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin picker, first request at/after ptr   |
// | Rev 1.0  : initial release                                                  |
// +-----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N    = 3,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  // Scan from the farthest offset back to ptr so the nearest request wins last.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDXW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ring_token_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ring_token_arbiter : ring stop sharing one token among NREQ local clients   |
// | Optional RING_ARB_STATS_EN adds grantCount / waitMax statistics outputs.    |
// | Rev 1.0  : initial release                                                  |
// +-----------------------------------------------------------------------------+
module ring_token_arbiter
  import ring_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int TOKEN_CORE = 1
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic [CORE_W-1:0] whichCore,
  input  wire logic [RING_W-1:0] RingIn,
  input  wire logic [SLOT_W-1:0] SlotTypeIn,
  input  wire logic [CORE_W-1:0] SourceIn,
  output logic      [RING_W-1:0] RingOut,
  output logic      [SLOT_W-1:0] SlotTypeOut,
  output logic      [CORE_W-1:0] SourceOut,
  output logic                   protoErr,
`ifdef RING_ARB_STATS_EN
  output logic [16*NREQ-1:0]     grantCount,
  output logic [15:0]            waitMax,
`endif
  ring_token_arbiter_if.slave    reqBus
);

  localparam int IDXW = $clog2(NREQ);

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_rrPtr;
  logic [IDXW-1:0] r_holder;
  slot_t           r_slot;
  logic            r_protoErr;

  logic [NREQ-1:0] w_gnt;
  logic [IDXW-1:0] w_gntIdx;
  logic            w_anyReq;
  logic            w_grant;
  logic            w_grantDrive;
  logic            w_holderDrive;
  slot_t           w_inSlot;
  slot_t           w_tokenSlot;
  slot_t           w_grantSlot;
  slot_t           w_holderSlot;

  logic [1:0]      w_nextState;
  slot_t           w_nextSlot;
  logic [IDXW-1:0] w_nextPtr;
  logic [IDXW-1:0] w_nextHolder;
  logic            w_setErr;

  rr_arbiter #(.N(NREQ), .IDXW(IDXW)) u_rr (
    .req (reqBus.wantsToken),
    .ptr (r_rrPtr),
    .gnt (w_gnt),
    .idx (w_gntIdx),
    .any (w_anyReq)
  );

  assign w_grant = !reset && (r_state == ST_IDLE) && (SlotTypeIn == SLOT_TOKEN) && w_anyReq;
  assign reqBus.acquireToken = w_grant ? w_gnt : '0;

  assign w_grantDrive  = reqBus.driveRing[w_gntIdx];
  assign w_holderDrive = reqBus.driveRing[r_holder];

  assign w_inSlot    = '{data: RingIn, slotType: SlotTypeIn, source: SourceIn};
  assign w_tokenSlot = '{data: '0, slotType: SLOT_TOKEN, source: whichCore};

  assign w_grantSlot = '{
    data:     reqBus.reqRingOut[RING_W*w_gntIdx +: RING_W],
    slotType: reqBus.reqSlotType[SLOT_W*w_gntIdx +: SLOT_W],
    source:   reqBus.reqSource[CORE_W*w_gntIdx +: CORE_W]
  };
  assign w_holderSlot = '{
    data:     reqBus.reqRingOut[RING_W*r_holder +: RING_W],
    slotType: reqBus.reqSlotType[SLOT_W*r_holder +: SLOT_W],
    source:   reqBus.reqSource[CORE_W*r_holder +: CORE_W]
  };

  always_comb begin
    w_nextState  = r_state;
    w_nextSlot   = r_slot;
    w_nextPtr    = r_rrPtr;
    w_nextHolder = r_holder;
    w_setErr     = 1'b0;
    case (r_state)
      ST_INJECT: begin
        w_nextSlot  = w_tokenSlot;
        w_nextState = ST_IDLE;
      end
      ST_HOLD: begin
        // Upstream traffic has nowhere to go while we own the ring.
        w_setErr = (SlotTypeIn != SLOT_NULL);
        if (w_holderDrive) begin
          w_nextSlot = w_holderSlot;
        end else begin
          w_nextSlot  = w_tokenSlot;
          w_nextPtr   = (r_holder == IDXW'(NREQ - 1)) ? '0 : r_holder + 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextSlot = w_inSlot;
        // A grantee that is not driving leaves the Token passing through.
        if (w_grant && w_grantDrive) begin
          w_nextSlot   = w_grantSlot;
          w_nextHolder = w_gntIdx;
          w_nextState  = ST_HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= (whichCore == CORE_W'(TOKEN_CORE)) ? ST_INJECT : ST_IDLE;
      r_slot     <= '{data: '0, slotType: SLOT_NULL, source: '0};
      r_rrPtr    <= '0;
      r_holder   <= '0;
      r_protoErr <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_slot     <= w_nextSlot;
      r_rrPtr    <= w_nextPtr;
      r_holder   <= w_nextHolder;
      r_protoErr <= r_protoErr | w_setErr;
    end
  end

  assign RingOut     = r_slot.data;
  assign SlotTypeOut = r_slot.slotType;
  assign SourceOut   = r_slot.source;
  assign protoErr    = r_protoErr;

`ifdef RING_ARB_STATS_EN
  logic [15:0] r_grantCnt [NREQ];
  logic [15:0] r_waitCnt  [NREQ];
  logic [15:0] r_waitMax;

  // waitCnt counts cycles wantsToken was held without a grant; sampled at grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_grantCnt[i] <= '0;
        r_waitCnt[i]  <= '0;
      end
      r_waitMax <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (reqBus.acquireToken[i]) begin
          if (r_grantCnt[i] != 16'hFFFF) r_grantCnt[i] <= r_grantCnt[i] + 16'd1;
          if (r_waitCnt[i] > r_waitMax) r_waitMax <= r_waitCnt[i];
          r_waitCnt[i] <= '0;
        end else if (reqBus.wantsToken[i]) begin
          if (r_waitCnt[i] != 16'hFFFF) r_waitCnt[i] <= r_waitCnt[i] + 16'd1;
        end else begin
          r_waitCnt[i] <= '0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_statOut
    assign grantCount[16*gi +: 16] = r_grantCnt[gi];
  end
  assign waitMax = r_waitMax;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_token_arbiter.sv
`default_nettype none
// Self-checking bench for ring_token_arbiter: a cycle model derived from the ring
// rules is compared every cycle, plus literal checks on the directed scenarios.
module tb_ring_token_arbiter;
  import ring_pkg::*;

  localparam int N  = 3;
  localparam int TC = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  whichCore = 4'd1;
  logic [31:0] RingIn = '0;
  logic [3:0]  SlotTypeIn = SLOT_NULL;
  logic [3:0]  SourceIn = '0;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut;
  logic [3:0]  SourceOut;
  logic        protoErr;

  ring_token_arbiter_if #(.NREQ(N)) bus();
`ifdef RING_ARB_STATS_EN
  logic [16*N-1:0] grantCount;
  logic [15:0]     waitMax;
`endif

  ring_token_arbiter #(.NREQ(N), .TOKEN_CORE(TC)) dut (
    .clock       (clock),
    .reset       (reset),
    .whichCore   (whichCore),
    .RingIn      (RingIn),
    .SlotTypeIn  (SlotTypeIn),
    .SourceIn    (SourceIn),
    .RingOut     (RingOut),
    .SlotTypeOut (SlotTypeOut),
    .SourceOut   (SourceOut),
    .protoErr    (protoErr),
`ifdef RING_ARB_STATS_EN
    .grantCount  (grantCount),
    .waitMax     (waitMax),
`endif
    .reqBus      (bus)
  );

  always #5 clock = ~clock;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mValid  = 0;
  bit          mInject = 0;
  int          mHolder = -1;
  int          mPtr    = 0;
  int          mG0     = 0;
  logic [31:0] mData   = '0;
  logic [3:0]  mType   = SLOT_NULL;
  logic [3:0]  mSrc    = '0;
  logic        mErr    = 1'b0;

  function automatic int pick(input logic [N-1:0] w, input int p);
    for (int k = 0; k < N; k++) begin
      if (w[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expAcq();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (reset || mInject || mHolder >= 0 || SlotTypeIn != SLOT_TOKEN) return r;
    g = pick(bus.wantsToken, mPtr);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic takeReq(input int i);
    mData = bus.reqRingOut[32*i +: 32];
    mType = bus.reqSlotType[4*i +: 4];
    mSrc  = bus.reqSource[4*i +: 4];
  endtask

  task automatic takeIn();
    mData = RingIn; mType = SlotTypeIn; mSrc = SourceIn;
  endtask

  always @(posedge clock) begin
    logic [N-1:0] a;
    int g;
    a = expAcq();
    g = pick(bus.wantsToken, mPtr);
    if (reset) begin
      mValid = 1; mData = '0; mType = SLOT_NULL; mSrc = '0; mErr = 1'b0;
      mPtr = 0; mHolder = -1; mG0 = 0; mInject = (whichCore == 4'(TC));
    end else begin
      if (a[0]) mG0++;
      if (mInject) begin
        mData = '0; mType = SLOT_TOKEN; mSrc = whichCore; mInject = 0;
      end else if (mHolder < 0) begin
        if (a != '0 && bus.driveRing[g]) begin
          takeReq(g); mHolder = g;
        end else begin
          takeIn();
        end
      end else begin
        if (SlotTypeIn != SLOT_NULL) mErr = 1'b1;
        if (bus.driveRing[mHolder]) takeReq(mHolder);
        else begin
          mData = '0; mType = SLOT_TOKEN; mSrc = whichCore;
          mPtr = (mHolder + 1) % N; mHolder = -1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (mValid) begin
      check("RingOut", RingOut, mData);
      check("SlotTypeOut", 32'(SlotTypeOut), 32'(mType));
      check("SourceOut", 32'(SourceOut), 32'(mSrc));
      check("protoErr", 32'(protoErr), 32'(mErr));
      check("acquireToken", 32'(bus.acquireToken), 32'(expAcq()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleIn();
    RingIn = '0; SlotTypeIn = SLOT_NULL; SourceIn = '0;
  endtask

  task automatic setReq(input int i, input logic [31:0] d, input logic [3:0] s);
    bus.reqRingOut[32*i +: 32] = d;
    bus.reqSlotType[4*i +: 4]  = SLOT_MESSAGE;
    bus.reqSource[4*i +: 4]    = s;
  endtask

  task automatic doReset(input logic [3:0] core);
    reset = 1'b1; whichCore = core;
    step(); step();
    reset = 1'b0;
  endtask

  // Token arrives, the granted requester sends only a header, then releases.
  task automatic grabAndRelease(input logic [N-1:0] expG, input logic [31:0] expHdr, input string nm);
    SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd9; #1;
    check(nm, 32'(bus.acquireToken), 32'(expG));
    bus.driveRing = bus.acquireToken;
    step();
    idleIn(); bus.driveRing = '0;
    check({nm, "_hdr"}, RingOut, expHdr);
    step();
    check({nm, "_tok"}, 32'(SlotTypeOut), 32'(SLOT_TOKEN));
  endtask

  initial begin
    bus.wantsToken = '0; bus.driveRing = '0;
    bus.reqRingOut = '0; bus.reqSlotType = '0; bus.reqSource = '0;
    setReq(0, 32'hA0000001, 4'd1);
    setReq(1, 32'hB0000001, 4'd2);
    setReq(2, 32'hC0000001, 4'd3);

    // Reset state, and no grant while reset is high even with Token + wants.
    reset = 1'b1; step(); step();
    check("rst_type", 32'(SlotTypeOut), 32'(SLOT_NULL));
    check("rst_ring", RingOut, 32'h0);
    check("rst_err", 32'(protoErr), 32'h0);
    SlotTypeIn = SLOT_TOKEN; bus.wantsToken = 3'b001; #1;
    check("rst_acq", 32'(bus.acquireToken), 32'h0);
    idleIn(); bus.wantsToken = '0;
    step();

    // Injection on the token core.
    reset = 1'b0;
    step();
    check("inj_type", 32'(SlotTypeOut), 32'(SLOT_TOKEN));
    check("inj_src", 32'(SourceOut), 32'h1);
    step();
    check("inj_after", 32'(SlotTypeOut), 32'(SLOT_NULL));

    // Passthrough.
    RingIn = 32'hDEAD0005; SlotTypeIn = SLOT_MESSAGE; SourceIn = 4'd3;
    step();
    idleIn();
    check("pass_ring", RingOut, 32'hDEAD0005);
    check("pass_type", 32'(SlotTypeOut), 32'(SLOT_MESSAGE));
    check("pass_src", 32'(SourceOut), 32'h3);

    // Single grant: header plus two words, then Token.
    bus.wantsToken = 3'b001; bus.driveRing = 3'b001;
    SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd5; #1;
    check("sg_acq", 32'(bus.acquireToken), 32'h1);
    step();
    idleIn(); setReq(0, 32'hA0000002, 4'd1);
    check("sg_w0", RingOut, 32'hA0000001);
    step();
    setReq(0, 32'hA0000003, 4'd1);
    check("sg_w1", RingOut, 32'hA0000002);
    step();
    bus.driveRing = '0; bus.wantsToken = '0;
    check("sg_w2", RingOut, 32'hA0000003);
    check("sg_w2type", 32'(SlotTypeOut), 32'(SLOT_MESSAGE));
    step();
    check("sg_tok", 32'(SlotTypeOut), 32'(SLOT_TOKEN));
    check("sg_toksrc", 32'(SourceOut), 32'h1);
    setReq(0, 32'hA0000001, 4'd1);

    // Contention from rrPtr=0.
    doReset(4'd1);
    step(); step();
    bus.wantsToken = 3'b111;
    grabAndRelease(3'b001, 32'hA0000001, "rr0");
    grabAndRelease(3'b010, 32'hB0000001, "rr1");
    grabAndRelease(3'b100, 32'hC0000001, "rr2");
    grabAndRelease(3'b001, 32'hA0000001, "rr3");

    // Zero-length send from req1 leaves rrPtr at 2.
    bus.wantsToken = 3'b010;
    grabAndRelease(3'b010, 32'hB0000001, "zl");
    bus.wantsToken = 3'b111;
    grabAndRelease(3'b100, 32'hC0000001, "zl_ptr");

    // Grantee not driving: Token passes through, no HOLD.
    bus.wantsToken = 3'b001;
    SlotTypeIn = SLOT_TOKEN; SourceIn = 4'd6; #1;
    check("nodrv_acq", 32'(bus.acquireToken), 32'h1);
    step();
    idleIn();
    check("nodrv_tok", 32'(SlotTypeOut), 32'(SLOT_TOKEN));
    check("nodrv_src", 32'(SourceOut), 32'h6);

    // Message dropped during HOLD sets protoErr.
    SlotTypeIn = SLOT_TOKEN; bus.driveRing = 3'b001; #1;
    step();
    RingIn = 32'h12345678; SlotTypeIn = SLOT_MESSAGE; SourceIn = 4'd4;
    step();
    check("drop_err", 32'(protoErr), 32'h1);
    check("drop_ring", RingOut, 32'hA0000001);
`ifdef RING_ARB_STATS_EN
    check("grantCount0", 32'(grantCount[15:0]), 32'(mG0));
`endif

    // Reset mid-HOLD.
    SlotTypeIn = SLOT_TOKEN; reset = 1'b1; whichCore = 4'd2; #1;
    check("midrst_acq", 32'(bus.acquireToken), 32'h0);
    step();
    check("midrst_type", 32'(SlotTypeOut), 32'(SLOT_NULL));
    check("midrst_err", 32'(protoErr), 32'h0);
    idleIn(); bus.driveRing = '0; bus.wantsToken = '0;
    step();
    reset = 1'b0;

    // Non-token core: no injection.
    step();
    check("noinj0", 32'(SlotTypeOut), 32'(SLOT_NULL));
    step();
    check("noinj1", 32'(SlotTypeOut), 32'(SLOT_NULL));
    RingIn = 32'h0BADF00D; SlotTypeIn = SLOT_MESSAGE; SourceIn = 4'd7;
    step();
    idleIn();
    check("noinj_msg", RingOut, 32'h0BADF00D);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
